// File: rtl/fpga_robots_game_tmarb.sv
// Tile map arbiter: two requesters share one tile map port.
//   A (game play) and B (serial host/debug) each present req/lock/adr/wrt/wen
//   and get a combinational gnt. Reads return on x_red/x_rvl RD_LAT cycles
//   after the transfer. A requester holding lock after its transfer keeps
//   exclusive ownership until it drops lock.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   a_* / b_*                 requester interfaces (req, lock, adr, wrt, wen
//                             in; gnt, red, rvl out)
//   m_adr, m_wrt, m_wen       tile map command, driven from granted requester
//   m_red                     tile map read data (RD_LAT cycles after address)
//   wait_cnt                  saturating count of cycles with a denied request
module fpga_robots_game_tmarb #(
  parameter int ADR_W  = 13,
  parameter int DAT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_lock,
  input  logic [ADR_W-1:0] a_adr,
  input  logic [DAT_W-1:0] a_wrt,
  input  logic             a_wen,
  output logic             a_gnt,
  output logic [DAT_W-1:0] a_red,
  output logic             a_rvl,
  input  logic             b_req,
  input  logic             b_lock,
  input  logic [ADR_W-1:0] b_adr,
  input  logic [DAT_W-1:0] b_wrt,
  input  logic             b_wen,
  output logic             b_gnt,
  output logic [DAT_W-1:0] b_red,
  output logic             b_rvl,
  output logic [ADR_W-1:0] m_adr,
  output logic [DAT_W-1:0] m_wrt,
  output logic             m_wen,
  input  logic [DAT_W-1:0] m_red,
  output logic [15:0]      wait_cnt
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t state, state_nxt;

  // 1: B was granted most recently, so A wins the next tie.
  logic last_b;

  logic              rd_push;
  logic              denied;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_b;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_b <= 1'b1;
    end else begin
      state <= state_nxt;
      if (a_gnt)      last_b <= 1'b0;
      else if (b_gnt) last_b <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (a_gnt && a_lock)                 state_nxt = LOCK_A;
    else if (b_gnt && b_lock)            state_nxt = LOCK_B;
    else if (state == LOCK_A && !a_lock) state_nxt = IDLE;
    else if (state == LOCK_B && !b_lock) state_nxt = IDLE;
  end

  // Grant logic: exclusive while the owner keeps lock, round-robin otherwise
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (state == LOCK_A && a_lock) begin
        a_gnt = a_req;
      end else if (state == LOCK_B && b_lock) begin
        b_gnt = b_req;
      end else if (a_req && b_req) begin
        a_gnt = last_b;
        b_gnt = !last_b;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Tile map command mux; A's inputs are presented when nobody is granted
  always_comb begin
    m_adr = b_gnt ? b_adr : a_adr;
    m_wrt = b_gnt ? b_wrt : a_wrt;
    m_wen = (a_gnt && a_wen) || (b_gnt && b_wen);
  end

  assign rd_push = (a_gnt && !a_wen) || (b_gnt && !b_wen);

  // Owner-tag pipeline: one slot per cycle of read latency, so back-to-back
  // reads from either requester return in issue order without merging.
  if (RD_LAT == 1) begin : g_pipe1
    always_ff @(posedge clk) begin
      if (rst) begin
        tag_v <= '0;
        tag_b <= '0;
      end else begin
        tag_v <= rd_push;
        tag_b <= b_gnt;
      end
    end
  end else begin : g_pipen
    always_ff @(posedge clk) begin
      if (rst) begin
        tag_v <= '0;
        tag_b <= '0;
      end else begin
        tag_v <= {tag_v[RD_LAT-2:0], rd_push};
        tag_b <= {tag_b[RD_LAT-2:0], b_gnt};
      end
    end
  end

  assign a_rvl = !rst && tag_v[RD_LAT-1] && !tag_b[RD_LAT-1];
  assign b_rvl = !rst && tag_v[RD_LAT-1] &&  tag_b[RD_LAT-1];
  assign a_red = m_red;
  assign b_red = m_red;

  // One increment per cycle even when both requesters are denied
  assign denied = (a_req && !a_gnt) || (b_req && !b_gnt);

  always_ff @(posedge clk) begin
    if (rst)                          wait_cnt <= '0;
    else if (denied && wait_cnt != '1) wait_cnt <= wait_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fpga_robots_game_tmarb.sv
// Testbench for fpga_robots_game_tmarb: a behavioural tile memory, an
// ownership/round-robin reference model feeding scoreboard queues, and a
// monitor comparing DUT outputs against the queues on the falling edge.
module tb_fpga_robots_game_tmarb;
  localparam int ADR_W  = 13;
  localparam int DAT_W  = 8;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  logic a_req, a_lock, a_wen, b_req, b_lock, b_wen;
  logic [ADR_W-1:0] a_adr, b_adr, m_adr;
  logic [DAT_W-1:0] a_wrt, b_wrt, m_wrt, a_red, b_red, m_red;
  logic a_gnt, a_rvl, b_gnt, b_rvl, m_wen;
  logic [15:0] wait_cnt;

  always #5 clk = ~clk;

  fpga_robots_game_tmarb #(.ADR_W(ADR_W), .DAT_W(DAT_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_adr(a_adr), .a_wrt(a_wrt), .a_wen(a_wen),
    .a_gnt(a_gnt), .a_red(a_red), .a_rvl(a_rvl),
    .b_req(b_req), .b_lock(b_lock), .b_adr(b_adr), .b_wrt(b_wrt), .b_wen(b_wen),
    .b_gnt(b_gnt), .b_red(b_red), .b_rvl(b_rvl),
    .m_adr(m_adr), .m_wrt(m_wrt), .m_wen(m_wen), .m_red(m_red),
    .wait_cnt(wait_cnt)
  );

  // Behavioural tile memory driven by the DUT's m_* outputs
  logic [DAT_W-1:0] phys [int];
  logic [DAT_W-1:0] dpipe [RD_LAT];
  logic             cap_wen = 1'b0;
  logic [ADR_W-1:0] cap_adr = '0;
  logic [DAT_W-1:0] cap_wrt = '0;

  always @(negedge clk) begin
    cap_wen = m_wen;
    cap_adr = m_adr;
    cap_wrt = m_wrt;
  end

  always @(posedge clk) begin
    logic [DAT_W-1:0] d;
    d = phys.exists(int'(cap_adr)) ? phys[int'(cap_adr)] : '0;
    if (cap_wen) phys[int'(cap_adr)] = cap_wrt;
    for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
    dpipe[0] = d;
  end

  assign m_red = dpipe[RD_LAT-1];

  // Scoreboard
  typedef struct {
    int               cyc;
    bit               a_gnt;
    bit               b_gnt;
    bit               m_wen;
    logic [ADR_W-1:0] m_adr;
    logic [DAT_W-1:0] m_wrt;
    int               wcnt;
  } exp_t;

  typedef struct {
    int               due;
    bit               own_b;
    logic [DAT_W-1:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req, input int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, req);
    end
  endtask

  // Reference model: owner (0 none, 1 A, 2 B), last winner, wait counter
  int               mdl_owner = 0;
  int               mdl_last  = 2;
  int               mdl_cnt   = 0;
  int               cyc       = 0;
  int               last_w    = 0;
  logic [DAT_W-1:0] model_mem [int];

  function automatic logic [DAT_W-1:0] mem_rd(input logic [ADR_W-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : '0;
  endfunction

  task automatic step();
    exp_t             e;
    int               w;
    bit               lk, we;
    logic [ADR_W-1:0] ad;
    logic [DAT_W-1:0] wd;
    w = 0;
    if (!rst) begin
      if (mdl_owner == 1 && a_lock)      w = a_req ? 1 : 0;
      else if (mdl_owner == 2 && b_lock) w = b_req ? 2 : 0;
      else if (a_req && b_req)           w = (mdl_last == 1) ? 2 : 1;
      else if (a_req)                    w = 1;
      else if (b_req)                    w = 2;
    end
    e.cyc   = cyc;
    e.wcnt  = mdl_cnt;
    e.a_gnt = (w == 1);
    e.b_gnt = (w == 2);
    e.m_adr = (w == 2) ? b_adr : a_adr;
    e.m_wrt = (w == 2) ? b_wrt : a_wrt;
    e.m_wen = (w == 1) ? a_wen : (w == 2) ? b_wen : 1'b0;
    if (rst) begin
      mdl_owner = 0;
      mdl_last  = 2;
      mdl_cnt   = 0;
      rd_q.delete();
    end else begin
      if (((a_req && w != 1) || (b_req && w != 2)) && mdl_cnt < 65535) mdl_cnt++;
      if (w != 0) begin
        lk = (w == 1) ? a_lock : b_lock;
        we = (w == 1) ? a_wen  : b_wen;
        ad = (w == 1) ? a_adr  : b_adr;
        wd = (w == 1) ? a_wrt  : b_wrt;
        if (we) model_mem[int'(ad)] = wd;
        else    rd_q.push_back('{cyc + RD_LAT, (w == 2), mem_rd(ad)});
        mdl_last  = w;
        mdl_owner = lk ? w : 0;
      end else if ((mdl_owner == 1 && !a_lock) || (mdl_owner == 2 && !b_lock)) begin
        mdl_owner = 0;
      end
    end
    exp_q.push_back(e);
    last_w = w;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    bit   ea, eb;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("a_gnt", 32'(a_gnt), 32'(e.a_gnt), e.cyc);
      check("b_gnt", 32'(b_gnt), 32'(e.b_gnt), e.cyc);
      check("m_wen", 32'(m_wen), 32'(e.m_wen), e.cyc);
      check("m_adr", 32'(m_adr), 32'(e.m_adr), e.cyc);
      check("m_wrt", 32'(m_wrt), 32'(e.m_wrt), e.cyc);
      check("wait_cnt", 32'(wait_cnt), 32'(e.wcnt), e.cyc);
      ea = 1'b0;
      eb = 1'b0;
      if (rd_q.size() > 0 && rd_q[0].due == e.cyc) begin
        ea = !rd_q[0].own_b;
        eb = rd_q[0].own_b;
        if (ea) check("a_red", 32'(a_red), 32'(rd_q[0].data), e.cyc);
        else    check("b_red", 32'(b_red), 32'(rd_q[0].data), e.cyc);
        void'(rd_q.pop_front());
      end
      check("a_rvl", 32'(a_rvl), 32'(ea), e.cyc);
      check("b_rvl", 32'(b_rvl), 32'(eb), e.cyc);
    end
  end

  task automatic rand_a();
    a_req  = ($urandom_range(0, 2) != 0);
    a_lock = ($urandom_range(0, 3) == 0);
    a_wen  = $urandom_range(0, 1);
    a_adr  = ADR_W'($urandom_range(0, 15));
    a_wrt  = DAT_W'($urandom);
  endtask

  task automatic rand_b();
    b_req  = ($urandom_range(0, 2) != 0);
    b_lock = ($urandom_range(0, 3) == 0);
    b_wen  = $urandom_range(0, 1);
    b_adr  = ADR_W'($urandom_range(0, 15));
    b_wrt  = DAT_W'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    a_req = 0; a_lock = 0; a_wen = 0; a_adr = '0; a_wrt = '0;
    b_req = 0; b_lock = 0; b_wen = 0; b_adr = '0; b_wrt = '0;
    @(posedge clk);
    #1;
    repeat (2) step();
    rst = 1'b0;

    // A alone: write 0x5A to 5, then read it back
    a_req = 1; a_wen = 1; a_adr = 13'h0005; a_wrt = 8'h5A; step();
    a_wen = 0; step();
    a_req = 0; repeat (4) step();

    // Both writing for 4 cycles after reset: A,B,A,B and wait_cnt reaches 4
    rst = 1; step(); rst = 0;
    a_req = 1; a_wen = 1; a_adr = 13'h0007; a_wrt = 8'h11;
    b_req = 1; b_wen = 1; b_adr = 13'h0008; b_wrt = 8'h22;
    repeat (4) step();
    a_req = 0; b_req = 0; step();

    // A locks, B waits 3 cycles, A drops lock and B wins the next tie
    a_req = 1; a_lock = 1; a_wen = 1; a_adr = 13'h0001; a_wrt = 8'h33; step();
    b_req = 1; b_wen = 1; b_adr = 13'h0002; b_wrt = 8'h44;
    repeat (3) step();
    a_lock = 0; step();
    step();
    a_req = 0; b_req = 0; step();
    // Lock held with no request, then released: ownership lapses without a grant
    a_lock = 1; a_req = 1; step(); a_req = 0; step(); a_lock = 0; step(); step();

    // Back-to-back reads A,B,A with alternating owners
    rst = 1; step(); rst = 0;
    a_req = 1; a_wen = 0; a_adr = 13'h0007;
    b_req = 1; b_wen = 0; b_adr = 13'h0008;
    repeat (3) step();
    a_req = 0; b_req = 0; repeat (5) step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(a_req && last_w != 1)) rand_a();
      if (!(b_req && last_w != 2)) rand_b();
      step();
    end
    rst = 0; a_req = 0; b_req = 0; a_lock = 0; b_lock = 0; repeat (6) step();

    // Saturation: A locked and writing, B starved
    rst = 1; step(); rst = 0;
    a_req = 1; a_lock = 1; a_wen = 1; a_adr = 13'h0003;
    b_req = 1; b_lock = 0; b_wen = 0; b_adr = 13'h0004;
    for (int n = 0; n < 70000; n++) begin
      a_wrt = DAT_W'(n);
      step();
    end
    // Read in flight when reset asserts: discarded
    a_wen = 0; step();
    rst = 1; a_req = 0; b_req = 0; a_lock = 0; step(); step();
    rst = 0; repeat (6) step();

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size() + rd_q.size()), 32'd0, cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpga_robots_game_tmarb.md
FPGA_ROBOTS_GAME_TMARB -- requirements
Module: fpga_robots_game_tmarb

Interface
REQ-001 Parameter ADR_W, 13, tile map address width.
REQ-002 Parameter DAT_W, 8, tile map data width.
REQ-003 Parameter RD_LAT, 1, tile map read latency in cycles; legal range 1..4.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 a_req  in  1  requester A (game play) access request.
REQ-007 a_lock  in  1  A asks to keep exclusive ownership after this access.
REQ-008 a_adr  in  ADR_W  A address.
REQ-009 a_wrt  in  DAT_W  A write data.
REQ-010 a_wen  in  1  A write enable; 0 means read.
REQ-011 a_gnt  out  1  A access accepted this cycle (combinational).
REQ-012 a_red  out  DAT_W  A read data.
REQ-013 a_rvl  out  1  A read data valid, one-cycle pulse.
REQ-014 b_req, b_lock, b_adr, b_wrt, b_wen, b_gnt, b_red, b_rvl: same as REQ-006..013, for requester B (serial host/debug).
REQ-015 m_adr  out  ADR_W  tile map address.
REQ-016 m_wrt  out  DAT_W  tile map write data.
REQ-017 m_wen  out  1  tile map write enable.
REQ-018 m_red  in  DAT_W  tile map read data, valid RD_LAT cycles after the address.
REQ-019 wait_cnt  out  16  saturating count of cycles in which a request was denied.

Function
REQ-020 Transfer occurs in a cycle iff x_req && x_gnt; at most one grant per cycle; a requester holds req, adr, wrt, wen and lock stable until granted.
REQ-021 States: IDLE, LOCK_A, LOCK_B.
REQ-022 In IDLE, or in LOCK_x with x_lock=0: round-robin arbitration. Sole requester wins. On contention, the requester not granted most recently wins. The round-robin pointer resets to "B last", so A wins the first tie.
REQ-023 In LOCK_x with x_lock=1: only x may be granted. The other requester's gnt is 0 regardless of its req.
REQ-024 Next state: transfer by x with x_lock=1 -> LOCK_x. Otherwise, when in LOCK_x with x_lock=0 -> IDLE. Otherwise hold.
REQ-025 Round-robin pointer updates only on a transfer, to the transferring requester.
REQ-026 m_adr/m_wrt/m_wen are driven combinationally from the granted requester. With no grant: m_wen=0, and m_adr/m_wrt carry requester A's inputs.
REQ-027 A read transfer (wen=0) pushes the owner tag into an RD_LAT-deep pipeline. Exactly RD_LAT cycles later, the owner's x_rvl pulses for 1 cycle and x_red=m_red in that cycle.
REQ-028 a_red and b_red pass m_red through continuously; only rvl qualifies them.
REQ-029 Back-to-back reads, including alternating owners, return in issue order with one rvl per read; no pulse is dropped or merged.
REQ-030 Write transfers produce no rvl.
REQ-031 wait_cnt increments by 1 in each cycle where some x_req=1 and x_gnt=0. It saturates at 16'hFFFF and never wraps. Two denied requesters in one cycle count once.
REQ-032 Lock deasserted while idle-owned, with no request: return to IDLE next cycle; no grant is issued.

Reset
REQ-033 While rst=1 (checked at the clock edge): state=IDLE, round-robin pointer="B last", read tag pipeline cleared, wait_cnt=0.
REQ-034 While rst=1: a_gnt=b_gnt=0, m_wen=0, a_rvl=b_rvl=0.
REQ-035 A read in flight when rst asserts is discarded; no rvl is produced for it after reset.

Verification
REQ-036 Only a_req, read adr 0x0005, RD_LAT=1 -> a_gnt=1 the same cycle, m_adr=0x0005, m_wen=0; next cycle a_rvl=1 with a_red=m_red; b_rvl stays 0.
REQ-037 a_req and b_req held high for 4 cycles after reset, both writes -> grants A,B,A,B; m_wen=1 each cycle; wait_cnt=4.
REQ-038 A transfers with a_lock=1, then B requests for 3 cycles while A keeps lock=1 and req=1 -> b_gnt=0 for those 3 cycles; A drops lock -> B granted on the next contended cycle.
REQ-039 RD_LAT=3, reads A,B,A on consecutive cycles -> rvl pattern a,b,a on cycles 3,4,5, each paired with the matching m_red.
REQ-040 b_req held with A locked for 70000 cycles -> wait_cnt saturates at 0xFFFF; assert rst mid-read -> wait_cnt=0 and no stray rvl afterwards.
